uart_bus_master: RTL and testbench

- Serial-to-bus bridge and initiator on the 16-bit memory bus: the other end of the memory-mapped responders (RAM, IO page, character memory).
- Takes received bytes from the buart receiver, parses read and write command frames, and issues word reads and writes on the bus.
- Replies through the buart transmitter.
- Asserts `hold` while a frame is in progress, so the top level can mux the bus away from FemtoRV32. It is used for loading firmware and fonts and for poking IO from a host.

---
 rtl/uart_bus_master.sv | 173 +++++++++++++++++
 tb/tb_uart_bus_master.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master.sv
// UART-to-bus bridge: parses 'W'/'R' frames from the byte receiver, runs one word
// access on the 16-bit memory bus and replies through the byte transmitter.
module uart_bus_master #(
    parameter int         TIMEOUT_CYCLES = 5000000,
    parameter logic [7:0] CMD_WRITE      = 8'h57,
    parameter logic [7:0] CMD_READ       = 8'h52,
    parameter logic [7:0] ACK_BYTE       = 8'h4B
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_rd,
    input  logic        tx_busy,
    output logic        tx_wr,
    output logic [7:0]  tx_data,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_rstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rbusy,
    output logic        hold
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_HI, S_ADDR_LO, S_DATA, S_WR,
        S_RD_REQ, S_RD_WAIT, S_TX, S_TX_GUARD, S_TX_WAIT
    } state_t;

    state_t        state_r;
    logic          is_write_r;
    logic          rx_skip_r;
    logic [1:0]    byte_cnt_r;
    logic [2:0]    tx_left_r;
    logic [31:0]   resp_r;
    logic [TW-1:0] tmo_r;

    logic receiving_s;
    logic frame_s;
    logic take_s;
    logic timeout_s;

    assign frame_s     = (state_r == S_ADDR_HI) || (state_r == S_ADDR_LO) || (state_r == S_DATA);
    assign receiving_s = (state_r == S_IDLE) || frame_s;
    // buart drops rx_valid one cycle after it sees rx_rd, so that stale cycle is skipped too
    assign take_s      = receiving_s && rx_valid && !rx_rd && !rx_skip_r;
    assign timeout_s   = (tmo_r == TW'(TIMEOUT_CYCLES - 1));

    // Frame parser, bus initiator and response sequencer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            is_write_r <= 1'b0;
            rx_skip_r  <= 1'b0;
            byte_cnt_r <= 2'd0;
            tx_left_r  <= 3'd0;
            resp_r     <= 32'd0;
            tmo_r      <= '0;
            rx_rd      <= 1'b0;
            tx_wr      <= 1'b0;
            tx_data    <= 8'd0;
            mem_addr   <= 16'd0;
            mem_wdata  <= 32'd0;
            mem_wmask  <= 4'd0;
            mem_rstrb  <= 1'b0;
            hold       <= 1'b0;
        end else begin
            rx_rd     <= take_s;
            rx_skip_r <= rx_rd;
            mem_wmask <= 4'd0;
            mem_rstrb <= 1'b0;
            tx_wr     <= 1'b0;
            if (frame_s && !take_s) begin
                tmo_r <= tmo_r + TW'(1);
            end else begin
                tmo_r <= '0;
            end

            case (state_r)
                S_IDLE: begin
                    if (take_s && ((rx_data == CMD_WRITE) || (rx_data == CMD_READ))) begin
                        is_write_r <= (rx_data == CMD_WRITE);
                        hold       <= 1'b1;
                        state_r    <= S_ADDR_HI;
                    end
                end
                S_ADDR_HI: begin
                    if (take_s) begin
                        mem_addr[15:8] <= rx_data;
                        state_r        <= S_ADDR_LO;
                    end else if (timeout_s) begin
                        hold    <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_ADDR_LO: begin
                    if (take_s) begin
                        mem_addr[7:0] <= {rx_data[7:2], 2'b00};
                        byte_cnt_r    <= 2'd0;
                        if (is_write_r) begin
                            state_r <= S_DATA;
                        end else begin
                            mem_rstrb <= 1'b1;
                            state_r   <= S_RD_REQ;
                        end
                    end else if (timeout_s) begin
                        hold    <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (take_s) begin
                        // LSB first: after four shifts the first byte sits in [7:0]
                        mem_wdata  <= {rx_data, mem_wdata[31:8]};
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            mem_wmask <= 4'b1111;
                            state_r   <= S_WR;
                        end
                    end else if (timeout_s) begin
                        hold    <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_WR: begin
                    resp_r    <= {24'd0, ACK_BYTE};
                    tx_left_r <= 3'd1;
                    state_r   <= S_TX;
                end
                S_RD_REQ: begin
                    state_r <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (!mem_rbusy) begin
                        resp_r    <= mem_rdata;
                        tx_left_r <= 3'd4;
                        state_r   <= S_TX;
                    end
                end
                S_TX: begin
                    if (!tx_busy) begin
                        tx_wr     <= 1'b1;
                        tx_data   <= resp_r[7:0];
                        resp_r    <= {8'd0, resp_r[31:8]};
                        tx_left_r <= tx_left_r - 3'd1;
                        state_r   <= S_TX_GUARD;
                    end
                end
                S_TX_GUARD: begin
                    state_r <= S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    if (!tx_busy) begin
                        if (tx_left_r != 3'd0) begin
                            state_r <= S_TX;
                        end else begin
                            hold    <= 1'b0;
                            state_r <= S_IDLE;
                        end
                    end
                end
                default: begin
                    hold    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: stimulus pushes expected bus cycles and tx
// bytes; a negedge monitor models buart/responder and pops/compares on DUT events.
module tb_uart_bus_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_rd;
    logic        tx_busy = 1'b0;
    logic        tx_wr;
    logic [7:0]  tx_data;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_rbusy = 1'b0;
    logic        hold;

    uart_bus_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_rd(rx_rd),
        .tx_busy(tx_busy), .tx_wr(tx_wr), .tx_data(tx_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata), .mem_rbusy(mem_rbusy),
        .hold(hold)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        logic [31:0] data;
    } bus_t;

    bus_t       exp_bus[$];
    logic [7:0] exp_tx[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rd_value = 32'd0;
    int          rd_busy_cycles = 0;
    int          busy_left = 0;
    logic [15:0] held_addr = 16'd0;
    int          tx_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: buart tx model, read responder model and scoreboard compares
    always @(negedge clk) begin
        bus_t b;
        if (!reset) begin
            if (mem_wmask != 4'd0 && mem_rstrb) check("wmask_rstrb_overlap", 32'd1, 32'd0);
            if (mem_wmask != 4'd0) begin
                if (exp_bus.size() == 0) begin
                    check("unexpected_write", {16'd0, mem_addr}, 32'hFFFFFFFF);
                end else begin
                    b = exp_bus.pop_front();
                    check("bus_kind_wr", 32'd1, {31'd0, b.is_wr});
                    check("wmask", {28'd0, mem_wmask}, 32'hF);
                    check("wr_addr", {16'd0, mem_addr}, {16'd0, b.addr});
                    check("wr_data", mem_wdata, b.data);
                end
            end
            if (mem_rstrb) begin
                if (exp_bus.size() == 0) begin
                    check("unexpected_read", {16'd0, mem_addr}, 32'hFFFFFFFF);
                end else begin
                    b = exp_bus.pop_front();
                    check("bus_kind_rd", 32'd0, {31'd0, b.is_wr});
                    check("rd_addr", {16'd0, mem_addr}, {16'd0, b.addr});
                end
                held_addr = mem_addr;
                if (rd_busy_cycles == 0) begin
                    mem_rbusy = 1'b0;
                    mem_rdata = rd_value;
                end else begin
                    mem_rbusy = 1'b1;
                    mem_rdata = 32'hBAD0BAD0;
                    busy_left = rd_busy_cycles;
                end
            end else if (busy_left > 0) begin
                check("rd_addr_held", {16'd0, mem_addr}, {16'd0, held_addr});
                busy_left--;
                if (busy_left == 0) begin
                    mem_rbusy = 1'b0;
                    mem_rdata = rd_value;
                end
            end
            if (tx_wr) begin
                check("tx_wr_while_busy", {31'd0, tx_busy}, 32'd0);
                if (exp_tx.size() == 0) begin
                    check("unexpected_tx", {24'd0, tx_data}, 32'hFFFFFFFF);
                end else begin
                    check("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
                end
                tx_busy = 1'b1;
                tx_left = 3;
            end else if (tx_left > 0) begin
                tx_left--;
                if (tx_left == 0) tx_busy = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rx_rd) begin
                got = 1'b1;
                break;
            end
        end
        rx_valid = 1'b0;
        if (!got) check("rx_rd_timeout", {24'd0, b}, 32'hFFFFFFFF);
        @(negedge clk);
    endtask

    task automatic wait_done(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_bus.size() == 0 && exp_tx.size() == 0 && !hold && !tx_busy) begin
                done = 1'b1;
                break;
            end
        end
        check({name, "_done"}, {31'd0, done}, 32'd1);
        check({name, "_hold_low"}, {31'd0, hold}, 32'd0);
        repeat (5) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_rx_rd", {31'd0, rx_rd}, 32'd0);
        check("rst_tx_wr", {31'd0, tx_wr}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wmask", {28'd0, mem_wmask}, 32'd0);
        check("rst_rstrb", {31'd0, mem_rstrb}, 32'd0);
        check("rst_hold", {31'd0, hold}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        do_reset();

        // Word write 0xDEADBEEF to 0x0010
        exp_bus.push_back('{1'b1, 16'h0010, 32'hDEADBEEF});
        exp_tx.push_back(8'h4B);
        send_byte(8'h57);
        check("hold_after_cmd", {31'd0, hold}, 32'd1);
        send_byte(8'h00); send_byte(8'h10);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        wait_done("write1");

        // Word read from 0x0010, immediate response
        do_reset();
        rd_value = 32'h12345678; rd_busy_cycles = 0;
        exp_bus.push_back('{1'b0, 16'h0010, 32'd0});
        exp_tx.push_back(8'h78); exp_tx.push_back(8'h56);
        exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
        wait_done("read1");

        // Unaligned read of 0x8003 with a slow responder
        rd_value = 32'hCAFEF00D; rd_busy_cycles = 5;
        exp_bus.push_back('{1'b0, 16'h8000, 32'd0});
        exp_tx.push_back(8'h0D); exp_tx.push_back(8'hF0);
        exp_tx.push_back(8'hFE); exp_tx.push_back(8'hCA);
        send_byte(8'h52); send_byte(8'h80); send_byte(8'h03);
        wait_done("read_busy");

        // Abandoned frame after inter-byte silence, then a normal write
        send_byte(8'h57); send_byte(8'h00);
        repeat (10) @(negedge clk);
        check("hold_before_timeout", {31'd0, hold}, 32'd1);
        repeat (8) @(negedge clk);
        check("hold_after_timeout", {31'd0, hold}, 32'd0);
        exp_bus.push_back('{1'b1, 16'h0104, 32'h44332211});
        exp_tx.push_back(8'h4B);
        send_byte(8'h57); send_byte(8'h01); send_byte(8'h04);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        wait_done("write_after_timeout");

        // Garbage bytes in idle, then a read
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h41);
        check("hold_after_garbage", {31'd0, hold}, 32'd0);
        rd_value = 32'hA5A55A5A; rd_busy_cycles = 0;
        exp_bus.push_back('{1'b0, 16'h0020, 32'd0});
        exp_tx.push_back(8'h5A); exp_tx.push_back(8'h5A);
        exp_tx.push_back(8'hA5); exp_tx.push_back(8'hA5);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h20);
        wait_done("read_after_garbage");

        // Reset in the middle of the data phase: no write, no reply
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'hEF); send_byte(8'hBE);
        check("hold_mid_frame", {31'd0, hold}, 32'd1);
        do_reset();
        repeat (30) @(negedge clk);
        check("no_write_after_reset", {31'd0, hold}, 32'd0);
        check("queues_empty", exp_bus.size() + exp_tx.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
